// File: rtl/register_writeback_queue_if.sv
// Handshake and register-file write bundle for register_writeback_queue.
// The producers and the register file sit on the master side; the queue is the slave.
interface register_writeback_queue_if #(
    parameter int unsigned REG_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned DEPTH_LOG2 = 2
);
    logic                  aValid;
    logic                  aReady;
    logic [ADDR_WIDTH-1:0] aAddr;
    logic [REG_WIDTH-1:0]  aData;
    logic                  bValid;
    logic                  bReady;
    logic [ADDR_WIDTH-1:0] bAddr;
    logic [REG_WIDTH-1:0]  bData;
    logic                  write;
    logic [ADDR_WIDTH-1:0] writeAddr;
    logic [REG_WIDTH-1:0]  writeData;
    logic [DEPTH_LOG2:0]   level;
    logic                  empty;

    modport master (
        output aValid, aAddr, aData, bValid, bAddr, bData,
        input  aReady, bReady, write, writeAddr, writeData, level, empty
    );

    modport slave (
        input  aValid, aAddr, aData, bValid, bAddr, bData,
        output aReady, bReady, write, writeAddr, writeData, level, empty
    );
endinterface

// File: rtl/register_writeback_queue.sv
// Two-producer in-order write-back queue draining one result per cycle into the register file.
// Optional same-cycle A bypass on an idle queue: define WRITEBACK_QUEUE_BYPASS_EN.
module register_writeback_queue #(
    parameter int unsigned REG_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned DEPTH_LOG2 = 2
) (
    input logic                     clock,
    input logic                     reset,
    register_writeback_queue_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [DEPTH_LOG2:0]   lvl_t;

    logic [ADDR_WIDTH-1:0] addrMem [DEPTH];
    logic [REG_WIDTH-1:0]  dataMem [DEPTH];

    ptr_t headQ, headD, tailQ, tailD, bIdx;
    lvl_t levelQ, levelD;
    logic isEmpty, aRdy, bRdy, aPush, bPush, aEnq, bEnq, pop, bypass;

    assign isEmpty = (levelQ == '0);
    assign aRdy    = (levelQ <= lvl_t'(DEPTH - 1));
    assign bRdy    = (levelQ <= lvl_t'(DEPTH - 2));

    // Handshakes and drains are suppressed while reset is asserted.
    assign aPush = reset & bus.aValid & aRdy;
    assign bPush = reset & bus.bValid & bRdy;
    assign pop   = reset & ~isEmpty;

`ifdef WRITEBACK_QUEUE_BYPASS_EN
    assign bypass = isEmpty & aPush;
`else
    assign bypass = 1'b0;
`endif

    assign aEnq = aPush & ~bypass;
    assign bEnq = bPush;
    assign bIdx = aEnq ? tailQ + ptr_t'(1) : tailQ;

    always_comb begin
        tailD  = tailQ + ptr_t'(aEnq) + ptr_t'(bEnq);
        headD  = headQ + ptr_t'(pop);
        levelD = levelQ + lvl_t'(aEnq) + lvl_t'(bEnq) - lvl_t'(pop);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            headQ  <= '0;
            tailQ  <= '0;
            levelQ <= '0;
        end else begin
            headQ  <= headD;
            tailQ  <= tailD;
            levelQ <= levelD;
        end
    end

    // Storage is intentionally not reset; occupancy alone defines validity.
    always_ff @(posedge clock) begin
        if (aEnq) begin
            addrMem[tailQ] <= bus.aAddr;
            dataMem[tailQ] <= bus.aData;
        end
        if (bEnq) begin
            addrMem[bIdx] <= bus.bAddr;
            dataMem[bIdx] <= bus.bData;
        end
    end

    always_comb begin
        bus.write     = 1'b0;
        bus.writeAddr = '0;
        bus.writeData = '0;
        if (pop) begin
            bus.write     = 1'b1;
            bus.writeAddr = addrMem[headQ];
            bus.writeData = dataMem[headQ];
        end else if (bypass) begin
            bus.write     = 1'b1;
            bus.writeAddr = bus.aAddr;
            bus.writeData = bus.aData;
        end
    end

    assign bus.aReady = aRdy;
    assign bus.bReady = bRdy;
    assign bus.level  = levelQ;
    assign bus.empty  = isEmpty;
endmodule

// File: tb/tb_register_writeback_queue.sv
// Directed bench for register_writeback_queue with a FIFO scoreboard of expected writes.
// Honours WRITEBACK_QUEUE_BYPASS_EN when the design is built with it.
module tb_register_writeback_queue;
    localparam int DEPTH = 4;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    register_writeback_queue_if #(.REG_WIDTH(8), .ADDR_WIDTH(3), .DEPTH_LOG2(2)) bus ();

    register_writeback_queue #(.REG_WIDTH(8), .ADDR_WIDTH(3), .DEPTH_LOG2(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int writes = 0;
    logic [10:0] sb [$];
    logic [7:0]  regs [8];
    logic [1:0]  tailModel = 2'd0;
    logic        lastA, lastB;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check outputs against the model, update the scoreboard, advance.
    task automatic tick();
        int sz;
        logic ax, bx, byp, expWr;
        logic [10:0] e;
        sz = sb.size();
        #1;
        if (!reset) begin
            check("write_in_reset", 32'(bus.write), 32'd0);
            lastA = 1'b0;
            lastB = 1'b0;
            @(posedge clock);
            sb.delete();
            tailModel = 2'd0;
        end else begin
            check("level", 32'(bus.level), 32'(sz));
            check("empty", 32'(bus.empty), 32'(sz == 0));
            check("aReady", 32'(bus.aReady), 32'(sz <= DEPTH - 1));
            check("bReady", 32'(bus.bReady), 32'(sz <= DEPTH - 2));
            ax = bus.aValid && (sz <= DEPTH - 1);
            bx = bus.bValid && (sz <= DEPTH - 2);
            byp = 1'b0;
`ifdef WRITEBACK_QUEUE_BYPASS_EN
            byp = ax && (sz == 0);
`endif
            if (ax) sb.push_back({bus.aAddr, bus.aData});
            if (bx) sb.push_back({bus.bAddr, bus.bData});
            tailModel = tailModel + 2'(ax && !byp) + 2'(bx);
            expWr = (sz != 0) || byp;
            check("write", 32'(bus.write), 32'(expWr));
            if (bus.write) begin
                regs[bus.writeAddr] = bus.writeData;
                writes++;
            end
            if (expWr && sb.size() > 0) begin
                e = sb.pop_front();
                check("writeAddr", 32'(bus.writeAddr), 32'(e[10:8]));
                check("writeData", 32'(bus.writeData), 32'(e[7:0]));
            end
            lastA = ax;
            lastB = bx;
            @(posedge clock);
        end
        @(negedge clock);
    endtask

    task automatic idle();
        bus.aValid = 1'b0;
        bus.bValid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0 && bus.empty) break;
            tick();
        end
        check("drained", 32'(bus.empty), 32'd1);
    endtask

    initial begin
        int w0, aSeq, bSeq, accepted;
        for (int i = 0; i < 8; i++) regs[i] = 8'h00;
        reset = 1'b0;
        bus.aValid = 1'b1; bus.aAddr = 3'd3; bus.aData = 8'h5A;
        bus.bValid = 1'b0; bus.bAddr = 3'd0; bus.bData = 8'h00;
        @(negedge clock);

        // Reset held for two edges with A valid: nothing queued afterwards.
        tick();
        tick();
        reset = 1'b1;
        idle();
        tick();
        tick();

        // Single A result.
        w0 = writes;
        bus.aValid = 1'b1; bus.aAddr = 3'd2; bus.aData = 8'h11;
        tick();
        idle();
        tick();
        tick();
        check("single_write_count", 32'(writes - w0), 32'd1);
        check("single_reg2", 32'(regs[2]), 32'h11);

        // Dual push to the same register: B must land last.
        bus.aValid = 1'b1; bus.aAddr = 3'd1; bus.aData = 8'hAA;
        bus.bValid = 1'b1; bus.bAddr = 3'd1; bus.bData = 8'hBB;
        tick();
        idle();
        drain();
        check("dual_reg1", 32'(regs[1]), 32'hBB);

        // Fill with both ports valid every cycle; producers hold until accepted.
        w0 = writes; aSeq = 0; bSeq = 0; accepted = 0;
        for (int i = 0; i < 100 && accepted < 32; i++) begin
            bus.aValid = 1'b1; bus.aAddr = 3'(aSeq); bus.aData = 8'(8'h40 + aSeq);
            bus.bValid = (accepted < 31); bus.bAddr = 3'(bSeq + 5); bus.bData = 8'(8'h80 + bSeq);
            tick();
            if (lastA) begin aSeq++; accepted++; end
            if (lastB) begin bSeq++; accepted++; end
        end
        check("fill_level_high", 32'(bus.level >= 3), 32'd1);
        idle();
        drain();
        check("fill_write_count", 32'(writes - w0), 32'd32);

        // Pointer wrap with B-only singles, then a dual push starting at tail 3.
        for (int i = 0; i < 9; i++) begin
            bus.bValid = 1'b1; bus.bAddr = 3'(i); bus.bData = 8'(8'hC0 + i);
            tick();
            idle();
            tick();
        end
        for (int i = 0; i < 8 && tailModel != 2'd3; i++) begin
            bus.bValid = 1'b1; bus.bAddr = 3'd4; bus.bData = 8'(8'hD0 + i);
            tick();
        end
        bus.aValid = 1'b1; bus.aAddr = 3'd6; bus.aData = 8'hE1;
        bus.bValid = 1'b1; bus.bAddr = 3'd6; bus.bData = 8'hE2;
        tick();
        idle();
        drain();
        check("wrap_reg6", 32'(regs[6]), 32'hE2);

        // Mid-operation reset with three entries queued.
        for (int i = 0; i < 10 && sb.size() < 3; i++) begin
            bus.aValid = 1'b1; bus.aAddr = 3'd5; bus.aData = 8'(8'h60 + i);
            bus.bValid = 1'b1; bus.bAddr = 3'd5; bus.bData = 8'(8'h70 + i);
            tick();
        end
        idle();
        #1;
        check("pre_reset_level", 32'(bus.level), 32'd3);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        bus.aValid = 1'b1; bus.aAddr = 3'd7; bus.aData = 8'h3C;
        tick();
        idle();
        drain();
        check("post_reset_reg7", 32'(regs[7]), 32'h3C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
